// File: rtl/sram_responder.sv
// Device-side model of the synchronous SRAM bus.
// Commits writes, returns pipelined read data and enforces a turnaround gap.
module sram_responder #(
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2,
  parameter int TURNAROUND   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  input  logic                  SRAM_WE_N,
  inout  wire  [DATA_WIDTH-1:0] SRAM_DQ,
  output logic                  dq_drive,
  output logic                  wr_strobe,
  output logic [15:0]           wr_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int LS = READ_LATENCY - 1;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [READ_LATENCY-1:0] r_vld;
  logic [DATA_WIDTH-1:0]   r_dat [READ_LATENCY];
  logic [1:0]              r_ta;

  logic [IW-1:0] w_idx;
  logic          w_wr;
  logic          w_unused_hi;

  assign w_idx       = SRAM_ADDR[IW-1:0];
  assign w_wr        = ~SRAM_WE_N;
  assign w_unused_hi = ^SRAM_ADDR[ADDR_WIDTH-1:IW];

  // Storage has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (rst && w_wr) begin
      r_mem[w_idx] <= SRAM_DQ;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld     <= '0;
      r_ta      <= 2'd0;
      wr_strobe <= 1'b0;
      wr_count  <= 16'd0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_dat[i] <= '0;
      end
    end else if (w_wr) begin
      r_vld     <= '0;
      r_ta      <= 2'(TURNAROUND);
      wr_strobe <= 1'b1;
      wr_count  <= wr_count + 16'd1;
    end else begin
      r_vld[0]  <= (r_ta == 2'd0);
      r_dat[0]  <= r_mem[w_idx];
      wr_strobe <= 1'b0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
      if (r_ta != 2'd0) begin
        r_ta <= r_ta - 2'd1;
      end
    end
  end

  // Combinational so drive drops the moment the initiator starts a write.
  assign dq_drive = SRAM_WE_N & r_vld[LS] & (r_ta == 2'd0);
  assign SRAM_DQ  = dq_drive ? r_dat[LS] : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder.
// Stimulus pushes expected read returns; a negedge monitor pops and compares.
module tb_sram_responder;

  localparam int AW    = 17;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int L     = 2;
  localparam int T     = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr = '0;
  logic          we_n = 1'b1;
  logic [DW-1:0] tb_dq = '0;
  wire  [DW-1:0] dq;
  wire           dq_drive;
  wire           wr_strobe;
  wire  [15:0]   wr_count;

  assign dq = we_n ? {DW{1'bz}} : tb_dq;

  sram_responder #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .READ_LATENCY(L),
    .TURNAROUND  (T)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SRAM_ADDR(addr),
    .SRAM_WE_N(we_n),
    .SRAM_DQ  (dq),
    .dq_drive (dq_drive),
    .wr_strobe(wr_strobe),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          known;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm    [DEPTH];
  bit          known [DEPTH];
  int          last_wr = -100;
  int          checks  = 0;
  int          errors  = 0;
  logic [15:0] m_cnt   = 16'd0;
  bit          m_prev  = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at edge %0d",
               name, act, exp, edge_n);
    end
  endtask

  // One bus cycle, sampled by the DUT at the next rising edge.
  task automatic op(bit wr, logic [AW-1:0] a, logic [31:0] d);
    int e;
    @(posedge clk);
    #1;
    e     = edge_n + 1;
    rst   = 1'b1;
    addr  = a;
    we_n  = ~wr;
    tb_dq = d;
    if (wr) begin
      mm[a[9:0]]    = d;
      known[a[9:0]] = 1'b1;
      q.delete();
      last_wr = e;
    end else if (e - last_wr > T) begin
      q.push_back('{due: e + L, data: mm[a[9:0]], known: known[a[9:0]]});
    end
  endtask

  task automatic do_reset(int cycles);
    rst  = 1'b0;
    we_n = 1'b1;
    addr = AW'($urandom);
    q.delete();
    last_wr = -100;
    repeat (cycles) @(posedge clk);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return AW'($urandom) & 17'h1FC3F;
  endfunction

  always @(negedge clk) begin
    automatic int   nx = edge_n + 1;
    automatic exp_t e;
    if (!rst) begin
      chk("rst_drive", {31'd0, dq_drive}, 32'd0);
      chk("rst_count", {16'd0, wr_count}, 32'd0);
      chk("rst_strobe", {31'd0, wr_strobe}, 32'd0);
      m_cnt  = 16'd0;
      m_prev = 1'b0;
    end else begin
      chk("wr_strobe", {31'd0, wr_strobe}, {31'd0, m_prev});
      chk("wr_count", {16'd0, wr_count}, {16'd0, m_cnt});
      if (q.size() > 0 && q[0].due < nx) begin
        e = q.pop_front();
        chk("missed_read", 32'(e.due), 32'(nx));
      end
      if (q.size() > 0 && q[0].due == nx) begin
        e = q.pop_front();
        chk("dq_drive", {31'd0, dq_drive}, 32'd1);
        if (e.known) chk("dq_data", dq, e.data);
      end else begin
        chk("dq_idle", {31'd0, dq_drive}, 32'd0);
      end
      m_prev = ~we_n;
      if (!we_n) m_cnt = m_cnt + 16'd1;
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    #1;
    do_reset(3);
    chk("reset_drive", {31'd0, dq_drive}, 32'd0);

    op(1'b1, 17'h00010, 32'hDEADBEEF);
    op(1'b0, 17'h00010, '0);
    op(1'b0, 17'h00010, '0);
    op(1'b0, 17'h00010, '0);
    op(1'b0, 17'h00010, '0);

    for (int i = 0; i < 8; i++) op(1'b1, AW'(i), 32'(i * 3));
    op(1'b0, 17'h0, '0);
    for (int i = 0; i < 8; i++) op(1'b0, AW'(i), '0);
    op(1'b0, 17'h0, '0);
    op(1'b0, 17'h0, '0);

    op(1'b1, 17'h00400, 32'h11111111);
    op(1'b0, 17'h00000, '0);
    op(1'b0, 17'h00000, '0);
    op(1'b0, 17'h00000, '0);
    op(1'b0, 17'h00000, '0);

    for (int i = 0; i < 64; i++) op(1'b1, rnd_addr() | AW'(i), $urandom);

    op(1'b0, 17'h3, '0);
    op(1'b0, 17'h4, '0);
    op(1'b1, 17'h5, 32'hA5A5A5A5);
    op(1'b0, 17'h5, '0);
    op(1'b0, 17'h5, '0);
    op(1'b0, 17'h5, '0);
    op(1'b0, 17'h5, '0);

    repeat (2000) begin
      if ($urandom_range(3) == 0) op(1'b1, rnd_addr(), $urandom);
      else op(1'b0, rnd_addr(), '0);
    end

    repeat (4) op(1'b0, rnd_addr(), '0);
    @(posedge clk);
    #3;
    chk("pre_rst_drive", {31'd0, dq_drive},
        {31'd0, (q.size() > 0 && q[0].due == edge_n + 1)});
    do_reset(0);
    #1;
    chk("async_rst_drive", {31'd0, dq_drive}, 32'd0);
    repeat (2) @(posedge clk);
    repeat (40) op(1'b0, rnd_addr(), '0);

    do_reset(2);
    repeat (65536) op(1'b1, rnd_addr(), $urandom);
    op(1'b0, rnd_addr(), '0);
    #1;
    chk("count_wrap", {16'd0, wr_count}, 32'd0);
    chk("strobe_last", {31'd0, wr_strobe}, 32'd1);
    repeat (6) op(1'b0, rnd_addr(), '0);
    @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
